// File: rtl/cr_osf_latency_mon.sv
// OSF egress latency monitor: snoops STAT TLVs on accepted
// beats and keeps latency statistics for the register block.
package cr_osf_pkg;

  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [7:0]  tid;
    logic [7:0]  tstrb;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } axi4s_dp_bus_t;

  localparam logic [7:0] TLV_RQE  = 8'h01;
  localparam logic [7:0] TLV_STAT = 8'h02;

  typedef struct packed {
    logic [7:0]  tlv_type;
    logic [7:0]  tlv_len;
    logic [47:0] rsvd;
  } tlv_word_0_t;

  typedef struct packed {
    logic [31:0] rsvd;
    logic [7:0]  frame_error;
    logic [23:0] latency;
  } tlv_stats_word2_t;

endpackage

module cr_osf_latency_mon
  import cr_osf_pkg::*;
#(
  parameter int SUM_W = 48,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  axi4s_dp_bus_t    axi4s_in,
  input  logic             axi4s_mstr_rd,
  input  logic [23:0]      lat_thresh,
  input  logic             stats_clr,
  output logic             lat_vld,
  output logic [23:0]      lat_last,
  output logic [23:0]      lat_min,
  output logic [23:0]      lat_max,
  output logic [SUM_W-1:0] lat_sum,
  output logic [CNT_W-1:0] frm_cnt,
  output logic [CNT_W-1:0] thresh_cnt,
  output logic [CNT_W-1:0] frm_err_cnt,
  output logic             thresh_irq
);

  typedef enum logic [1:0] {IDLE, W1, W2} state_t;

  state_t           state;
  tlv_word_0_t      w0;
  tlv_stats_word2_t w2;
  logic             acc, sot, eot, is_stat, cap;
  logic [23:0]      lat;
  logic             over, ferr;
  logic             unused_bits;

  assign w0      = axi4s_in.tdata;
  assign w2      = axi4s_in.tdata;
  assign acc     = axi4s_in.tvalid & axi4s_mstr_rd;
  assign sot     = axi4s_in.tuser == 8'h1;
  assign eot     = axi4s_in.tuser == 8'h2;
  assign is_stat = w0.tlv_type == TLV_STAT;
  assign lat     = w2.latency;
  assign over    = lat > lat_thresh;
  assign ferr    = |w2.frame_error;
  // a sot on word 2 aborts the TLV instead of capturing it
  assign cap     = acc & ~sot & (state == W2);

  assign unused_bits = ^{axi4s_in.tlast, axi4s_in.tid,
                         axi4s_in.tstrb, w0.tlv_len,
                         w0.rsvd, w2.rsvd};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (acc & sot) begin
      state <= is_stat ? W1 : IDLE;
    end else if (acc) begin
      unique case (state)
        IDLE:    state <= IDLE;
        W1:      state <= eot ? IDLE : W2;
        W2:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [23:0]      min_b, max_b;
  logic [SUM_W-1:0] sum_b, sum_sat;
  logic [SUM_W:0]   sum_nx;
  logic [CNT_W-1:0] frm_b, thr_b, err_b;

  // clear feeds the update path so a coincident sample lands on it
  always_comb begin
    min_b = lat_min;
    max_b = lat_max;
    sum_b = lat_sum;
    frm_b = frm_cnt;
    thr_b = thresh_cnt;
    err_b = frm_err_cnt;
    if (stats_clr) begin
      min_b = '1;
      max_b = '0;
      sum_b = '0;
      frm_b = '0;
      thr_b = '0;
      err_b = '0;
    end
  end

  assign sum_nx  = {1'b0, sum_b} + (SUM_W+1)'(lat);
  assign sum_sat = sum_nx[SUM_W] ? {SUM_W{1'b1}}
                                 : sum_nx[SUM_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_vld     <= 1'b0;
      thresh_irq  <= 1'b0;
      lat_last    <= '0;
      lat_min     <= '1;
      lat_max     <= '0;
      lat_sum     <= '0;
      frm_cnt     <= '0;
      thresh_cnt  <= '0;
      frm_err_cnt <= '0;
    end else begin
      lat_vld     <= cap;
      thresh_irq  <= cap & over;
      if (cap) lat_last <= lat;
      lat_min     <= (cap && lat < min_b) ? lat : min_b;
      lat_max     <= (cap && lat > max_b) ? lat : max_b;
      lat_sum     <= cap ? sum_sat : sum_b;
      frm_cnt     <= cap ? sat_inc(frm_b) : frm_b;
      thresh_cnt  <= (cap & over) ? sat_inc(thr_b) : thr_b;
      frm_err_cnt <= (cap & ferr) ? sat_inc(err_b) : err_b;
    end
  end

endmodule
